wb_stage: RTL
=============

Name: wb_stage

Overview:
Final (writeback) pipeline stage of the 5-stage LoongArch core. It consumes the memory stage's output bus and commits each retiring instruction: general-register write, CSR read/write, exception and ertn commit, and the forward bus and debug trace. It is the single source of the pipeline-wide flush signals (final_ex, back_ertn_flush) that all upstream stages use to kill their contents.

Parameters:
BUS_WD, 192, width of ms_to_ws_bus (equals `MS_TO_WS_BUS_WD)
TID_CSR_NUM, 14'h40, CSR number used for rdcntid

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
ws_allowin  out  1  stage can accept a new instruction
ms_to_ws_valid  in  1  memory stage presents a valid instruction
ms_to_ws_bus  in  192  fields [191] rdcntid, [190:159] vaddr, [158] ertn, [157] esubcode, [156:151] ecode, [150] ex, [149] csr_re, [148:135] csr_num, [134:103] csr_wvalue, [102:71] csr_wmask, [70] csr_we, [69] gr_we, [68:64] dest, [63:32] result, [31:0] pc
rf_we  out  1  regfile write enable
rf_waddr  out  5  regfile write address
rf_wdata  out  32  regfile write data
csr_re  out  1  CSR read enable
csr_num  out  14  CSR read/write index
csr_rvalue  in  32  CSR read data (combinational)
csr_we  out  1  CSR write enable
csr_wmask  out  32  CSR write mask
csr_wvalue  out  32  CSR write value
wb_ex  out  1  exception commit, to CSR file
wb_ecode  out  6  exception code
wb_esubcode  out  9  exception subcode, zero-extended from the 1-bit bus field
wb_pc  out  32  pc of the committing instruction
wb_vaddr  out  32  faulting address, for BADV
final_ex  out  1  exception flush to all stages
back_ertn_flush  out  1  ertn flush to all stages
ws_forward  out  40  [39] csr_block, [38:7] rf_wdata, [6:2] dest, [1] rf_we, [0] ws_valid
debug_wb_pc  out  32  trace pc
debug_wb_rf_we  out  4  trace byte enables
debug_wb_rf_wnum  out  5  trace register
debug_wb_rf_wdata  out  32  trace data

Behaviour:
- ws_ready_go = 1. ws_allowin = !ws_valid || ws_ready_go.
- ws_valid reset value is 0. On any cycle with reset | final_ex | back_ertn_flush, ws_valid <= 0. Otherwise, when ws_allowin, ws_valid <= ms_to_ws_valid.
- The bus register latches ms_to_ws_bus when ms_to_ws_valid && ws_allowin and is not cleared by flush.
- Every output is qualified by ws_valid, so after reset all outputs are 0 regardless of bus register contents.
- final_ex = ws_valid & ex. It is combinational and occurs in the same cycle the instruction sits in WB.
- back_ertn_flush = ws_valid & ertn & ~ex. Exception has priority over ertn.
- wb_ex = final_ex. wb_ecode, wb_esubcode, wb_pc and wb_vaddr are the bus fields when wb_ex is 1, and 0 otherwise.
- csr_re = ws_valid & (csr_re_field | rdcntid).
- csr_num = rdcntid ? TID_CSR_NUM : csr_num field.
- csr_we = ws_valid & csr_we_field & ~ex.
- rf_we = ws_valid & gr_we & ~ex. rf_waddr = dest.
- rf_wdata = csr_re ? csr_rvalue : result.
- A write to r0 is passed through; the regfile ignores it.
- csr_block = ws_valid & csr_re. Upstream decode stalls on a CSR read-after-write hazard using this bit.
- Debug trace: debug_wb_pc = pc & {32{ws_valid}}, debug_wb_rf_we = {4{rf_we}}, and wnum/wdata equal rf_waddr/rf_wdata.
- Simultaneous events: an instruction arriving in the same cycle as final_ex is dropped, because ws_valid is forced to 0. The flushing instruction itself retires that cycle and is not held.
- Reset mid-operation: the in-flight instruction is discarded with no rf or csr write. Reset itself produces no final_ex.

Optional Feature:
WB_INST_CNT_EN:
- Defined: adds output inst_retired_cnt, 64 bits. It resets to 0 and increments by 1 each cycle with ws_valid & ~ex, including ertn. It wraps from 2^64-1 to 0.
- Undefined: the port and the counter are absent, and the rest of the behaviour is identical.

Test Plan:
- add.w writeback: bus gr_we=1, dest=5, result=0x1234_5678, valid for 1 cycle -> next cycle rf_we=1, rf_waddr=5, rf_wdata=0x12345678, debug_wb_rf_we=4'hf.
- csrrd: csr_re=1, csr_num=0x5, csr_rvalue=0xDEAD_BEEF, dest=3 -> rf_wdata=0xDEADBEEF, ws_forward[39]=1.
- rdcntid: rdcntid=1, csr_num field=0 -> csr_num=0x40, csr_re=1, rf_wdata=csr_rvalue.
- Syscall: ex=1, ecode=0x0B, gr_we=1, csr_we=1, with a new instruction presented the same cycle -> final_ex=1, wb_ecode=0x0B, rf_we=0, csr_we=0. The next cycle ws_valid=0 and the new instruction is dropped.
- ertn together with ex (ex=1, ertn=1) -> final_ex=1, back_ertn_flush=0. ertn alone -> back_ertn_flush=1, and the next cycle ws_valid=0.
- Reset asserted while ws_valid=1 with gr_we=1 -> all outputs 0 the following cycle. With WB_INST_CNT_EN defined, 3 back-to-back valid non-exception instructions -> inst_retired_cnt=3.

Source files
------------

// File: rtl/wb_stage.sv
// Writeback stage of the 5-stage LoongArch core: retires instructions and generates the pipeline-wide flushes.
// Optional: define WB_INST_CNT_EN to add a 64-bit retired-instruction counter output (inst_retired_cnt).
module wb_stage #(
    parameter int          BUS_WD      = 192,
    parameter logic [13:0] TID_CSR_NUM = 14'h40
) (
    input  logic              clk,
    input  logic              reset,
    output logic              ws_allowin,
    input  logic              ms_to_ws_valid,
    input  logic [BUS_WD-1:0] ms_to_ws_bus,
    output logic              rf_we,
    output logic [4:0]        rf_waddr,
    output logic [31:0]       rf_wdata,
    output logic              csr_re,
    output logic [13:0]       csr_num,
    input  logic [31:0]       csr_rvalue,
    output logic              csr_we,
    output logic [31:0]       csr_wmask,
    output logic [31:0]       csr_wvalue,
    output logic              wb_ex,
    output logic [5:0]        wb_ecode,
    output logic [8:0]        wb_esubcode,
    output logic [31:0]       wb_pc,
    output logic [31:0]       wb_vaddr,
    output logic              final_ex,
    output logic              back_ertn_flush,
    output logic [39:0]       ws_forward,
    output logic [31:0]       debug_wb_pc,
    output logic [3:0]        debug_wb_rf_we,
    output logic [4:0]        debug_wb_rf_wnum,
    output logic [31:0]       debug_wb_rf_wdata
`ifdef WB_INST_CNT_EN
    ,
    output logic [63:0]       inst_retired_cnt
`endif
);

    typedef struct packed {
        logic        rdcntid;
        logic [31:0] vaddr;
        logic        ertn;
        logic        esubcode;
        logic [5:0]  ecode;
        logic        ex;
        logic        csr_re;
        logic [13:0] csr_num;
        logic [31:0] csr_wvalue;
        logic [31:0] csr_wmask;
        logic        csr_we;
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] result;
        logic [31:0] pc;
    } ws_bus_t;

    logic              ws_valid_q;
    logic              ws_valid_d;
    logic [BUS_WD-1:0] ws_bus_q;
    ws_bus_t           ws_bus;
    logic              ws_ready_go;
    logic              ws_ex;

    assign ws_ready_go = 1'b1;
    assign ws_allowin  = !ws_valid_q || ws_ready_go;
    assign ws_bus      = ws_bus_t'(ws_bus_q);
    assign ws_ex       = ws_valid_q & ws_bus.ex;

    always_comb begin
        ws_valid_d = ws_valid_q;
        if (reset || final_ex || back_ertn_flush) begin
            ws_valid_d = 1'b0;
        end else if (ws_allowin) begin
            ws_valid_d = ms_to_ws_valid;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        ws_valid_q <= ws_valid_d;
    end

    // NOTE: the payload register is deliberately not reset; ws_valid_q gates every use of it.
    always_ff @(posedge clk) begin
        if (ms_to_ws_valid && ws_allowin) begin
            ws_bus_q <= ms_to_ws_bus;
        end
    end

    // Flushes: exception wins over ertn when both are flagged.
    assign final_ex        = ws_ex;
    assign back_ertn_flush = ws_valid_q & ws_bus.ertn & ~ws_bus.ex;

    assign wb_ex       = final_ex;
    assign wb_ecode    = wb_ex ? ws_bus.ecode : 6'd0;
    assign wb_esubcode = wb_ex ? {8'd0, ws_bus.esubcode} : 9'd0;
    assign wb_pc       = wb_ex ? ws_bus.pc : 32'd0;
    assign wb_vaddr    = wb_ex ? ws_bus.vaddr : 32'd0;

    assign csr_re     = ws_valid_q & (ws_bus.csr_re | ws_bus.rdcntid);
    assign csr_num    = !ws_valid_q    ? 14'd0
                      : ws_bus.rdcntid ? TID_CSR_NUM
                      :                  ws_bus.csr_num;
    assign csr_we     = ws_valid_q & ws_bus.csr_we & ~ws_bus.ex;
    assign csr_wmask  = ws_valid_q ? ws_bus.csr_wmask : 32'd0;
    assign csr_wvalue = ws_valid_q ? ws_bus.csr_wvalue : 32'd0;

    assign rf_we    = ws_valid_q & ws_bus.gr_we & ~ws_bus.ex;
    assign rf_waddr = ws_valid_q ? ws_bus.dest : 5'd0;
    assign rf_wdata = !ws_valid_q ? 32'd0
                    : csr_re      ? csr_rvalue
                    :               ws_bus.result;

    assign ws_forward = {csr_re, rf_wdata, rf_waddr, rf_we, ws_valid_q};

    assign debug_wb_pc       = ws_bus.pc & {32{ws_valid_q}};
    assign debug_wb_rf_we    = {4{rf_we}};
    assign debug_wb_rf_wnum  = rf_waddr;
    assign debug_wb_rf_wdata = rf_wdata;

`ifdef WB_INST_CNT_EN
    logic [63:0] cnt_q;
    logic [63:0] cnt_d;

    // Counts every retiring non-exception instruction, ertn included; wraps naturally.
    always_comb begin
        cnt_d = cnt_q;
        if (ws_valid_q && !ws_bus.ex) begin
            cnt_d = cnt_q + 64'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= 64'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign inst_retired_cnt = cnt_q;
`endif

endmodule
